// File: rtl/booth_multiplier_if.sv
// booth_multiplier_if
//   Handshake and data bundle between the operand registers and the
//   sequential Booth multiplier.
//   Parameter N : operand width (product is 2N bits).
//   Signals:
//     start   - request, sampled by the multiplier only while idle
//     a, b    - signed multiplicand / multiplier, captured on accepted start
//     busy    - multiplier is not idle
//     done    - one-cycle pulse, product valid
//     product - signed 2N-bit product, held until the next completion
//     ovf     - product does not fit in N signed bits
//               (present only when MUL_OVF_FLAG_EN is defined)
//   Modports: master (requester side), slave (multiplier side).
interface booth_multiplier_if #(
  parameter int N = 32
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
`ifdef MUL_OVF_FLAG_EN
  logic           ovf;

  modport master (output start, a, b, input busy, done, product, ovf);
  modport slave  (input start, a, b, output busy, done, product, ovf);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif
endinterface

// File: rtl/booth_multiplier.sv
// booth_multiplier
//   Sequential signed radix-2 Booth multiplier. Produces a 2N-bit product
//   from two N-bit two's-complement operands in N iterations; each iteration
//   is one add/subtract/no-op on an (N+1)-bit accumulator followed by an
//   arithmetic shift right of {A, Q, q_1}.
//   Ports:
//     clk     - rising-edge clock
//     reset_n - asynchronous active-low reset
//     bus     - booth_multiplier_if.slave (start, a, b, busy, done, product
//               and, with MUL_OVF_FLAG_EN, ovf)
//   Optional feature macro: MUL_OVF_FLAG_EN enables the registered ovf flag.

// Ripple-carry add/subtract stage; sub=1 computes x - y (two's complement).
module booth_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum
);
  logic [W-1:0] carry;
  logic [W-1:0] y_eff;

  assign carry[0] = sub;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign y_eff[gi] = y[gi] ^ sub;
    assign sum[gi]   = x[gi] ^ y_eff[gi] ^ carry[gi];
    // Carry out of the top bit is discarded: arithmetic is modulo 2^W.
    if (gi < W - 1) begin : g_carry
      assign carry[gi+1] = (x[gi] & y_eff[gi]) | (carry[gi] & (x[gi] ^ y_eff[gi]));
    end
  end
endmodule

module booth_multiplier #(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  booth_multiplier_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N:0]     m_q, m_d;
  logic [N:0]     acc_q, acc_d;
  logic [N-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N:0]     addsub_sum;
  logic [N:0]     acc_step;
  logic [N:0]     acc_shift;
  logic [N-1:0]   q_shift;

  // Q[0]=1 selects subtract; the operation result is only used when
  // Q[0] != q_1, otherwise the accumulator passes through unchanged.
  booth_addsub #(.W(N + 1)) u_addsub (
    .x   (acc_q),
    .y   (m_q),
    .sub (q_q[0]),
    .sum (addsub_sum)
  );

  assign acc_step  = (q_q[0] ^ q1_q) ? addsub_sum : acc_q;
  assign acc_shift = {acc_step[N], acc_step[N:1]};
  assign q_shift   = {acc_step[0], q_q[N-1:1]};

`ifdef MUL_OVF_FLAG_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    count_d   = count_q;
    product_d = product_q;
`ifdef MUL_OVF_FLAG_EN
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = {bus.a[N-1], bus.a};
          acc_d   = '0;
          q_d     = bus.b;
          q1_d    = 1'b0;
          count_d = CW'(N);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_shift;
        q_d     = q_shift;
        q1_d    = q_q[0];
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          product_d = {acc_shift[N-1:0], q_shift};
`ifdef MUL_OVF_FLAG_EN
          // Fits in N signed bits only if the top N+1 bits are all equal.
          ovf_d = ~((&product_d[2*N-1:N-1]) | ~(|product_d[2*N-1:N-1]));
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
`ifdef MUL_OVF_FLAG_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      product_q <= product_d;
`ifdef MUL_OVF_FLAG_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;
`ifdef MUL_OVF_FLAG_EN
  assign bus.ovf     = ovf_q;
`endif
endmodule

// File: tb/tb_booth_multiplier.sv
// Testbench for booth_multiplier (N=32): scoreboard of expected products fed
// by the stimulus process, checked by an independent monitor on done.
module tb_booth_multiplier;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  booth_multiplier_if #(.N(N)) bus_if();

  booth_multiplier #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        ovf;
    int          acc_cycle;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  logic [63:0] last_prod = '0;
  exp_t        e;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
    exp_t   r;
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r.a = a;
    r.b = b;
    r.prod = p;
    r.ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    r.acc_cycle = acc;
    return r;
  endfunction

  // Monitor: compare on every done pulse; between pulses product must hold.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_prod = '0;
    end else if (bus_if.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cycle);
      end else begin
        e = sb.pop_front();
        $display("txn a=%h b=%h product=%h expected=%h", e.a, e.b, bus_if.product, e.prod);
        check("product", bus_if.product, e.prod);
        check("latency", 64'(cycle), 64'(e.acc_cycle + N));
`ifdef MUL_OVF_FLAG_EN
        check("ovf", 64'(bus_if.ovf), 64'(e.ovf));
`endif
        last_prod = e.prod;
      end
    end else begin
      check("product_hold", bus_if.product, last_prod);
    end
  end

  // Wait for idle, then pulse start with the given operands.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while (bus_if.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (bus_if.busy) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got busy=1 expected busy=0");
    end
    bus_if.a = a;
    bus_if.b = b;
    bus_if.start = 1'b1;
    sb.push_back(model(a, b, cycle + 1));
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sb.size() != 0 || bus_if.busy) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0 || bus_if.busy) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending=%0d expected pending=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1;
    int acc2;
    int guard;
    logic [31:0] corners [6];
    logic [31:0] ra;
    logic [31:0] rb;
    corners = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0001_0000};

    bus_if.start = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;
    #12;
    check("reset_busy", 64'(bus_if.busy), 64'd0);
    check("reset_done", 64'(bus_if.done), 64'd0);
    check("reset_product", bus_if.product, 64'd0);
`ifdef MUL_OVF_FLAG_EN
    check("reset_ovf", 64'(bus_if.ovf), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // 13*12: done in cycle after E32, busy low after E33.
    issue(32'd13, 32'd12);
    guard = 0;
    while (!bus_if.done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", 64'(bus_if.done), 64'd1);
    check("busy_in_done", 64'(bus_if.busy), 64'd1);
    @(negedge clk);
    check("busy_after", 64'(bus_if.busy), 64'd0);
    check("done_pulse", 64'(bus_if.done), 64'd0);

    issue(-32'sd7, 32'd5);
    issue(32'd5, -32'sd7);
    issue(32'h8000_0000, 32'h8000_0000);
    issue(32'h8000_0000, 32'd1);
    issue(32'd65536, 32'd65536);
    issue(32'd0, 32'h1234_5678);
    wait_drain();

    // start during RUN with other operands is ignored.
    issue(32'd3, 32'd4);
    repeat (4) @(negedge clk);
    bus_if.a = 32'd9;
    bus_if.b = 32'd9;
    bus_if.start = 1'b1;
    repeat (5) @(negedge clk);
    bus_if.start = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);

    // start held high: second accept exactly N+2 edges after the first.
    bus_if.a = 32'd1000;
    bus_if.b = -32'sd3;
    bus_if.start = 1'b1;
    acc1 = cycle + 1;
    sb.push_back(model(32'd1000, -32'sd3, acc1));
    @(negedge clk);
    bus_if.a = -32'sd77;
    bus_if.b = 32'd123;
    guard = 0;
    while (bus_if.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    acc2 = cycle + 1;
    sb.push_back(model(-32'sd77, 32'd123, acc2));
    check("b2b_gap", 64'(acc2 - acc1), 64'(N + 2));
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_drain();

    // Asynchronous reset mid-RUN.
    issue(32'd11, 32'd22);
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus_if.busy), 64'd0);
    check("arst_done", 64'(bus_if.done), 64'd0);
    check("arst_product", bus_if.product, 64'd0);
`ifdef MUL_OVF_FLAG_EN
    check("arst_ovf", 64'(bus_if.ovf), 64'd0);
`endif
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_drain();

    // Randomized operands, with corner values mixed in.
    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
      issue(ra, rb);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
